// File: rtl/spi_cs_arbiter.sv
// spi_cs_arbiter: two-port round-robin front end for a byte-level SPI master.
// Owns chip-select timing (setup / hold / idle gap) and the master's TX/RX handshake.
//
// Ports:
//   i_Clk, i_Rst_L            clock, async active-low reset
//   i_Req[1:0]                per-port transaction request (level, sampled in IDLE)
//   i_Len_Mn1[15:0]           per-port byte count minus one (port n: [8n+7:8n])
//   i_TX_Byte[15:0]           per-port next TX byte (port n: [8n+7:8n])
//   i_TX_Valid[1:0]           per-port TX byte valid
//   o_TX_Take[1:0]            owner's byte consumed (1-cycle pulse)
//   o_RX_Byte[7:0]            received byte, shared
//   o_RX_DV[1:0]              received byte valid, to owner
//   o_Gnt[1:0]                one-hot grant, held for the transaction
//   o_Done[1:0]               pulse to owner when its CS deasserts
//   o_Busy                    not idle
//   o_SPI_CS_n[1:0]           active-low chip selects
//   o_M_TX_Byte, o_M_TX_DV    byte + strobe to SPI master
//   i_M_TX_Ready              SPI master ready
//   i_M_RX_DV, i_M_RX_Byte    SPI master received byte

module spi_cs_arbiter #(
    parameter int CS_SETUP_CLKS = 4,
    parameter int CS_HOLD_CLKS  = 4,
    parameter int CS_IDLE_CLKS  = 8
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [1:0]  i_Req,
    input  logic [15:0] i_Len_Mn1,
    input  logic [15:0] i_TX_Byte,
    input  logic [1:0]  i_TX_Valid,
    output logic [1:0]  o_TX_Take,
    output logic [7:0]  o_RX_Byte,
    output logic [1:0]  o_RX_DV,
    output logic [1:0]  o_Gnt,
    output logic [1:0]  o_Done,
    output logic        o_Busy,
    output logic [1:0]  o_SPI_CS_n,
    output logic [7:0]  o_M_TX_Byte,
    output logic        o_M_TX_DV,
    input  logic        i_M_TX_Ready,
    input  logic        i_M_RX_DV,
    input  logic [7:0]  i_M_RX_Byte
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // Terminal values of the shared phase timer.
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD_CLKS - 1);
    localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE_CLKS - 1);

    logic [2:0]  state_q,   state_d;
    logic [15:0] tmr_q,     tmr_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic        own_q,     own_d;
    logic        last_q,    last_d;
    logic [1:0]  gnt_q,     gnt_d;
    logic [1:0]  cs_n_q,    cs_n_d;
    logic [1:0]  done_q,    done_d;
    logic        rx_seen_q, rx_seen_d;
    logic        wfirst_q,  wfirst_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic [1:0]  rx_dv_q,   rx_dv_d;

    logic        pick;
    logic [7:0]  len_sel;
    logic        own_valid;
    logic [7:0]  own_byte;
    logic        issue;
    logic        wait_exit;

    // Both requesting: serve the port that was not served last.
    assign pick      = (&i_Req) ? ~last_q : i_Req[1];
    assign len_sel   = pick ? i_Len_Mn1[15:8] : i_Len_Mn1[7:0];

    assign own_valid = own_q ? i_TX_Valid[1] : i_TX_Valid[0];
    assign own_byte  = own_q ? i_TX_Byte[15:8] : i_TX_Byte[7:0];

    // Issue is combinational so the strobe can never coincide with Ready low.
    assign issue     = (state_q == ST_LOAD) && own_valid && i_M_TX_Ready;

    // Exit is blocked in the first WAIT cycle so the master's Ready can fall.
    assign wait_exit = !wfirst_q && rx_seen_q && i_M_TX_Ready;

    assign o_M_TX_DV   = issue;
    assign o_M_TX_Byte = issue ? own_byte : 8'h00;
    assign o_TX_Take   = issue ? gnt_q : 2'b00;

    assign o_Gnt      = gnt_q;
    assign o_SPI_CS_n = cs_n_q;
    assign o_Done     = done_q;
    assign o_RX_Byte  = rx_byte_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_Busy     = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cs_n_d    = cs_n_q;
        done_d    = 2'b00;
        rx_seen_d = rx_seen_q;
        wfirst_d  = wfirst_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|i_Req) begin
                    state_d = ST_SETUP;
                    tmr_d   = 16'd0;
                    own_d   = pick;
                    cnt_d   = len_sel;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    cs_n_d  = pick ? 2'b01 : 2'b10;
                end
            end
            ST_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    state_d = ST_LOAD;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_LOAD: begin
                if (issue) begin
                    state_d   = ST_WAIT;
                    rx_seen_d = 1'b0;
                    wfirst_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                wfirst_d = 1'b0;
                if (i_M_RX_DV) begin
                    rx_seen_d = 1'b1;
                end
                if (wait_exit) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_HOLD;
                        tmr_d   = 16'd0;
                    end else begin
                        state_d = ST_LOAD;
                        cnt_d   = cnt_q - 8'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    state_d = ST_GAP;
                    tmr_d   = 16'd0;
                    cs_n_d  = 2'b11;
                    gnt_d   = 2'b00;
                    done_d  = gnt_q;
                    last_d  = own_q;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            ST_GAP: begin
                if (tmr_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                    tmr_d   = 16'd0;
                end else begin
                    tmr_d = tmr_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = 16'd0;
                gnt_d   = 2'b00;
                cs_n_d  = 2'b11;
            end
        endcase
    end

    // Received bytes are steered to whoever holds the grant, in any state.
    always_comb begin
        rx_byte_d = rx_byte_q;
        rx_dv_d   = 2'b00;
        if (i_M_RX_DV && (|gnt_q)) begin
            rx_byte_d = i_M_RX_Byte;
            rx_dv_d   = gnt_q;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            tmr_q     <= 16'd0;
            cnt_q     <= 8'd0;
            own_q     <= 1'b0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            cs_n_q    <= 2'b11;
            done_q    <= 2'b00;
            rx_seen_q <= 1'b0;
            wfirst_q  <= 1'b0;
            rx_byte_q <= 8'h00;
            rx_dv_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            rx_seen_q <= rx_seen_d;
            wfirst_q  <= wfirst_d;
            rx_byte_q <= rx_byte_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// tb_spi_cs_arbiter: randomized bench for spi_cs_arbiter.
// Transaction-level requester/master models and a scoreboard.

module tb_spi_cs_arbiter;

    localparam int CS_SETUP = 3;
    localparam int CS_HOLD  = 5;
    localparam int CS_IDLE  = 7;

    logic        i_Clk = 1'b0;
    logic        i_Rst_L;
    logic [1:0]  i_Req;
    logic [15:0] i_Len_Mn1;
    logic [15:0] i_TX_Byte;
    logic [1:0]  i_TX_Valid;
    logic [1:0]  o_TX_Take;
    logic [7:0]  o_RX_Byte;
    logic [1:0]  o_RX_DV;
    logic [1:0]  o_Gnt;
    logic [1:0]  o_Done;
    logic        o_Busy;
    logic [1:0]  o_SPI_CS_n;
    logic [7:0]  o_M_TX_Byte;
    logic        o_M_TX_DV;
    logic        i_M_TX_Ready;
    logic        i_M_RX_DV;
    logic [7:0]  i_M_RX_Byte;

    spi_cs_arbiter #(
        .CS_SETUP_CLKS(CS_SETUP),
        .CS_HOLD_CLKS (CS_HOLD),
        .CS_IDLE_CLKS (CS_IDLE)
    ) dut (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Req       (i_Req),
        .i_Len_Mn1   (i_Len_Mn1),
        .i_TX_Byte   (i_TX_Byte),
        .i_TX_Valid  (i_TX_Valid),
        .o_TX_Take   (o_TX_Take),
        .o_RX_Byte   (o_RX_Byte),
        .o_RX_DV     (o_RX_DV),
        .o_Gnt       (o_Gnt),
        .o_Done      (o_Done),
        .o_Busy      (o_Busy),
        .o_SPI_CS_n  (o_SPI_CS_n),
        .o_M_TX_Byte (o_M_TX_Byte),
        .o_M_TX_DV   (o_M_TX_DV),
        .i_M_TX_Ready(i_M_TX_Ready),
        .i_M_RX_DV   (i_M_RX_DV),
        .i_M_RX_Byte (i_M_RX_Byte)
    );

    always #5 i_Clk = ~i_Clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Pending (not yet granted) transactions per port.
    int         pq_len [2][$];
    int         pq_sa  [2][$];
    int         pq_sl  [2][$];
    logic [7:0] pq_b   [2][$];

    // Transaction in flight.
    logic [7:0] txq [$];
    logic [7:0] rxq [$];
    int         served [$];
    bit   active = 0;
    int   cur = 0, cur_len = 0, sent = 0, rxc = 0;
    int   sa = -1, sl = 0, stall = 0;
    int   g_cyc = 0, ex_cyc = -1000, hi_run = 0;
    bit   had_done = 0, pend_gnt = 0, first_dv = 0;
    int   exp_port = 0, last = 1;
    int   done_cnt = 0, exp_done = 0;
    logic [1:0] gprev = 2'b00;
    bit   busy_s = 0;

    // SPI master model (loopback: MISO returns MOSI).
    int         m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    bit         rdy_prev = 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic add_txn(input int p, input int len, input int s_at,
                           input int s_len, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
        pq_len[p].push_back(len);
        pq_sa[p].push_back(s_at);
        pq_sl[p].push_back(s_len);
        for (int i = 0; i < len; i++) begin
            if (i == 0)      pq_b[p].push_back(b0);
            else if (i == 1) pq_b[p].push_back(b1);
            else if (i == 2) pq_b[p].push_back(b2);
            else             pq_b[p].push_back(8'($urandom));
        end
        exp_done++;
    endtask

    task automatic start_txn(input int p);
        cur = p;
        if (pq_len[p].size() == 0) return;
        cur_len = pq_len[p].pop_front();
        sa = pq_sa[p].pop_front();
        sl = pq_sl[p].pop_front();
        txq.delete();
        rxq.delete();
        for (int i = 0; i < cur_len; i++) txq.push_back(pq_b[p].pop_front());
        sent = 0;
        rxc = 0;
        stall = 0;
        g_cyc = cyc;
        first_dv = 0;
        active = 1;
    endtask

    task automatic step();
        logic [1:0]  rq, v, ng;
        logic [15:0] lm, tb;
        @(negedge i_Clk);
        rq = 2'b00;
        v  = 2'b00;
        lm = 16'($urandom);
        tb = 16'($urandom);
        for (int n = 0; n < 2; n++) begin
            if (pq_len[n].size() != 0) begin
                rq[n] = 1'b1;
                lm[n*8 +: 8] = 8'(pq_len[n][0] - 1);
            end
            if (active && cur == n) begin
                v[n] = (txq.size() != 0) && (stall == 0);
                if (v[n]) tb[n*8 +: 8] = txq[0];
            end else begin
                v[n] = 1'($urandom);
            end
        end
        i_Req        = rq;
        i_Len_Mn1    = lm;
        i_TX_Byte    = tb;
        i_TX_Valid   = v;
        i_M_TX_Ready = (m_cnt == 0);
        i_M_RX_DV    = (m_cnt == 2);
        i_M_RX_Byte  = (m_cnt == 2) ? m_byte : 8'($urandom);
        #1;
        busy_s = o_Busy;
        if (stall > 0) stall--;

        ng = ~o_Gnt;
        chk("cs_vs_gnt", 32'(o_SPI_CS_n), 32'(ng));
        chk("gnt_2hot", 32'(o_Gnt == 2'b11), 32'd0);

        if (pend_gnt) begin
            chk("gnt", 32'(o_Gnt), 32'(1 << exp_port));
            if (had_done) chk("gap", 32'(hi_run > CS_IDLE), 32'd1);
            start_txn(exp_port);
        end else if (o_Gnt != 2'b00 && gprev == 2'b00) begin
            chk("spur_gnt", 32'(o_Gnt), 32'd0);
        end
        if (o_SPI_CS_n == 2'b11) hi_run++;
        else hi_run = 0;

        if (active && o_Done == 2'b00)
            chk("gnt_hold", 32'(o_Gnt), 32'(1 << cur));

        if (o_M_TX_DV) begin
            chk("dv_ready", 32'(i_M_TX_Ready), 32'd1);
            if (active && txq.size() != 0) begin
                chk("dv_valid", 32'(i_TX_Valid[cur]), 32'd1);
                chk("take", 32'(o_TX_Take), 32'(1 << cur));
                chk("tx_byte", 32'(o_M_TX_Byte), 32'(txq[0]));
                if (!first_dv) begin
                    chk("setup", 32'(cyc - g_cyc), 32'(CS_SETUP));
                    first_dv = 1;
                end
                rxq.push_back(txq.pop_front());
                sent++;
                if (sent == sa) stall = sl;
            end else begin
                chk("spur_dv", 32'(o_M_TX_DV), 32'd0);
            end
        end else if (o_TX_Take != 2'b00) begin
            chk("take_no_dv", 32'(o_TX_Take), 32'd0);
        end

        if (o_RX_DV != 2'b00) begin
            if (active && rxq.size() != 0) begin
                chk("rx_dv", 32'(o_RX_DV), 32'(1 << cur));
                chk("rx_byte", 32'(o_RX_Byte), 32'(rxq[0]));
                void'(rxq.pop_front());
                rxc++;
            end else begin
                chk("spur_rx", 32'(o_RX_DV), 32'd0);
            end
        end

        if (active && i_M_TX_Ready && !rdy_prev &&
            sent == cur_len && rxc == cur_len)
            ex_cyc = cyc;

        if (o_Done != 2'b00) begin
            if (active) begin
                chk("done", 32'(o_Done), 32'(1 << cur));
                chk("n_tx", 32'(sent), 32'(cur_len));
                chk("n_rx", 32'(rxc), 32'(cur_len));
                chk("hold", 32'(cyc - ex_cyc), 32'(CS_HOLD + 1));
                chk("cs_up", 32'(o_SPI_CS_n), 32'd3);
                last = cur;
                served.push_back(cur);
                had_done = 1;
                active = 0;
                done_cnt++;
            end else begin
                chk("spur_done", 32'(o_Done), 32'd0);
            end
        end

        if (m_cnt > 0) m_cnt--;
        if (o_M_TX_DV && i_M_TX_Ready) begin
            m_cnt  = $urandom_range(3, 12);
            m_byte = o_M_TX_Byte;
        end
        pend_gnt = i_Rst_L && !o_Busy && (i_Req != 2'b00);
        exp_port = (i_Req == 2'b11) ? (1 - last) : (i_Req[1] ? 1 : 0);
        rdy_prev = i_M_TX_Ready;
        gprev = o_Gnt;
        cyc++;
    endtask

    task automatic reset_dut();
        @(negedge i_Clk);
        i_Rst_L = 1'b0;
        #1;
        chk("rst_cs", 32'(o_SPI_CS_n), 32'd3);
        chk("rst_gnt", 32'(o_Gnt), 32'd0);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_txdv", 32'(o_M_TX_DV), 32'd0);
        chk("rst_take", 32'(o_TX_Take), 32'd0);
        chk("rst_rxdv", 32'(o_RX_DV), 32'd0);
        chk("rst_rxb", 32'(o_RX_Byte), 32'd0);
        chk("rst_txb", 32'(o_M_TX_Byte), 32'd0);
        exp_done -= (active ? 1 : 0) + pq_len[0].size() + pq_len[1].size();
        for (int n = 0; n < 2; n++) begin
            pq_len[n].delete();
            pq_sa[n].delete();
            pq_sl[n].delete();
            pq_b[n].delete();
        end
        active = 0;
        pend_gnt = 0;
        m_cnt = 0;
        stall = 0;
        last = 1;
        had_done = 0;
        gprev = 2'b00;
        hi_run = 0;
        rdy_prev = 1;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
    endtask

    task automatic run(input int max);
        for (int i = 0; i < max; i++) begin
            step();
            if (pq_len[0].size() == 0 && pq_len[1].size() == 0 &&
                !active && !pend_gnt && !busy_s)
                return;
        end
        chk("timeout", 32'(busy_s), 32'd0);
    endtask

    initial begin
        int np;
        i_Rst_L      = 1'b0;
        i_Req        = 2'b00;
        i_Len_Mn1    = 16'h0000;
        i_TX_Byte    = 16'h0000;
        i_TX_Valid   = 2'b00;
        i_M_TX_Ready = 1'b1;
        i_M_RX_DV    = 1'b0;
        i_M_RX_Byte  = 8'h00;
        reset_dut();

        add_txn(0, 1, -1, 0, 8'hA5, 8'h00, 8'h00);
        run(2000);

        add_txn(1, 3, -1, 0, 8'h11, 8'h22, 8'h33);
        run(2000);

        reset_dut();
        served.delete();
        add_txn(0, 2, -1, 0, 8'h5A, 8'hC3, 8'h00);
        add_txn(1, 2, -1, 0, 8'h3C, 8'h96, 8'h00);
        add_txn(0, 1, -1, 0, 8'h7E, 8'h00, 8'h00);
        run(3000);
        chk("rr_count", 32'(served.size()), 32'd3);
        if (served.size() == 3) begin
            chk("rr_0", 32'(served[0]), 32'd0);
            chk("rr_1", 32'(served[1]), 32'd1);
            chk("rr_2", 32'(served[2]), 32'd0);
        end

        add_txn(0, 4, 2, 20, 8'hDE, 8'hAD, 8'hBE);
        run(3000);

        add_txn(0, 4, -1, 0, 8'h01, 8'h02, 8'h03);
        for (int i = 0; i < 2000 && !(active && sent >= 2); i++) step();
        chk("mid_reach", 32'(active && sent >= 2), 32'd1);
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_done", 32'(o_Done), 32'd0);
        end
        add_txn(1, 2, -1, 0, 8'hF0, 8'h0F, 8'h00);
        run(2000);

        add_txn(0, 4, -1, 0, 8'h44, 8'h55, 8'h66);
        run(2000);

        add_txn(1, 256, -1, 0, 8'h80, 8'h81, 8'h82);
        run(8000);

        for (int k = 0; k < 24; k++) begin
            np = $urandom_range(1, 3);
            for (int j = 0; j < np; j++) begin
                int p, ln, s_at;
                p = $urandom_range(0, 1);
                ln = $urandom_range(1, 8);
                s_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ln) : -1;
                add_txn(p, ln, s_at, $urandom_range(1, 15),
                        8'($urandom), 8'($urandom), 8'($urandom));
            end
            run(6000);
        end

        chk("n_done", 32'(done_cnt), 32'(exp_done));
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
